// File: rtl/sdram_access_arbiter.sv
// Sequenced two-port grant in front of sdram_ctrl: S (spi_flash) has priority, U is protected from starvation.
// Grant latency 1 cycle; the grant holds until sd_ack or the watchdog expires, and acks route combinationally to the owner.
module sdram_access_arbiter #(
    parameter int ACK_TIMEOUT  = 64,
    parameter int U_STARVE_MAX = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_critical,
    input  logic        spi_refresh_inh,
    input  logic        s_enable,
    input  logic        s_we,
    input  logic [31:0] s_addr,
    input  logic [15:0] s_wr_data,
    input  logic [1:0]  s_wr_mask,
    output logic        s_ack,
    input  logic        u_enable,
    input  logic        u_we,
    input  logic [31:0] u_addr,
    input  logic [15:0] u_wr_data,
    input  logic [1:0]  u_wr_mask,
    output logic        u_ack,
    output logic        u_idle,
    output logic        sd_enable,
    output logic        sd_we,
    output logic [31:0] sd_addr,
    output logic [15:0] sd_wr_data,
    output logic [1:0]  sd_wr_mask,
    output logic        sd_refresh_inh,
    input  logic        sd_ack,
    input  logic        sd_idle,
    output logic [7:0]  timeout_count,
    output logic [1:0]  grant
);
    localparam int SW = $clog2(U_STARVE_MAX + 1);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(U_STARVE_MAX);
    localparam logic [WW-1:0] WD_LAST    = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_S, GRANT_U, FLUSH} state_t;

    state_t        state;
    logic [SW-1:0] starve;
    logic [WW-1:0] wdog;
    logic          u_ok;
    logic          force_u;
    logic          pick_u;
    logic          pick_s;

    assign u_ok    = u_enable && !spi_critical;
    assign force_u = u_ok && (starve == STARVE_MAX);
    assign pick_u  = force_u || (!s_enable && u_ok && sd_idle);
    assign pick_s  = s_enable && !force_u;

    // Acks are gated by the registered owner so a stray sd_ack never reaches the wrong port.
    assign s_ack  = (state == GRANT_S) && sd_ack;
    assign u_ack  = (state == GRANT_U) && sd_ack;
    assign u_idle = sd_idle && !spi_critical && (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            starve         <= '0;
            wdog           <= '0;
            sd_enable      <= 1'b0;
            sd_we          <= 1'b0;
            sd_addr        <= '0;
            sd_wr_data     <= '0;
            sd_wr_mask     <= '0;
            sd_refresh_inh <= 1'b0;
            timeout_count  <= '0;
            grant          <= 2'b00;
        end else begin
            sd_refresh_inh <= spi_critical && spi_refresh_inh;

            if (!u_enable)
                starve <= '0;
            else if (state == IDLE && pick_u)
                starve <= '0;
            else if (state == IDLE && pick_s && !spi_critical && starve != STARVE_MAX)
                starve <= starve + 1'b1;

            case (state)
                IDLE: begin
                    if (sd_ack && timeout_count != 8'hFF)
                        timeout_count <= timeout_count + 1'b1;
                    if (pick_u) begin
                        state      <= GRANT_U;
                        grant      <= 2'b10;
                        sd_enable  <= 1'b1;
                        sd_we      <= u_we;
                        sd_addr    <= u_addr;
                        sd_wr_data <= u_wr_data;
                        sd_wr_mask <= u_wr_mask;
                        wdog       <= '0;
                    end else if (pick_s) begin
                        state      <= GRANT_S;
                        grant      <= 2'b01;
                        sd_enable  <= 1'b1;
                        sd_we      <= s_we;
                        sd_addr    <= s_addr;
                        sd_wr_data <= s_wr_data;
                        sd_wr_mask <= s_wr_mask;
                        wdog       <= '0;
                    end
                end
                GRANT_S, GRANT_U: begin
                    if (sd_ack) begin
                        state     <= IDLE;
                        grant     <= 2'b00;
                        sd_enable <= 1'b0;
                    end else if (wdog == WD_LAST) begin
                        // Abandon the access; the controller may still be busy, so drain in FLUSH.
                        state     <= FLUSH;
                        grant     <= 2'b00;
                        sd_enable <= 1'b0;
                        if (timeout_count != 8'hFF)
                            timeout_count <= timeout_count + 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                FLUSH: begin
                    if (sd_idle)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench: a cycle table for basic arbitration plus hand sequences for starvation, critical, timeout and reset.
module tb_sdram_access_arbiter;
    localparam logic [31:0] SA = 32'h0000_0123;
    localparam logic [31:0] UA = 32'h0000_ABCD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_critical, spi_refresh_inh;
    logic        s_enable, s_we, u_enable, u_we;
    logic [31:0] s_addr, u_addr, sd_addr;
    logic [15:0] s_wr_data, u_wr_data, sd_wr_data;
    logic [1:0]  s_wr_mask, u_wr_mask, sd_wr_mask;
    logic        s_ack, u_ack, u_idle;
    logic        sd_enable, sd_we, sd_refresh_inh, sd_ack, sd_idle;
    logic [7:0]  timeout_count;
    logic [1:0]  grant;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram_access_arbiter #(.ACK_TIMEOUT(64), .U_STARVE_MAX(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_critical(spi_critical), .spi_refresh_inh(spi_refresh_inh),
        .s_enable(s_enable), .s_we(s_we), .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_wr_mask(s_wr_mask), .s_ack(s_ack),
        .u_enable(u_enable), .u_we(u_we), .u_addr(u_addr), .u_wr_data(u_wr_data),
        .u_wr_mask(u_wr_mask), .u_ack(u_ack), .u_idle(u_idle),
        .sd_enable(sd_enable), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wr_data(sd_wr_data),
        .sd_wr_mask(sd_wr_mask), .sd_refresh_inh(sd_refresh_inh),
        .sd_ack(sd_ack), .sd_idle(sd_idle),
        .timeout_count(timeout_count), .grant(grant)
    );

    typedef struct packed {
        logic [5:0]  in;    // s_en, u_en, crit, rinh, sd_ack, sd_idle
        logic [6:0]  ex;    // sd_en, grant[1:0], s_ack, u_ack, u_idle, sd_refresh_inh
        logic [31:0] addr;
        logic [7:0]  tc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [5:0] in, input logic [6:0] ex,
                                input logic [31:0] addr, input logic [7:0] tc);
        vec_t v;
        v.in = in; v.ex = ex; v.addr = addr; v.tc = tc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where sd_enable is first seen high, or flags a timeout.
    task automatic wait_en(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = sd_enable;
        end
        chk({nm, "_grant_seen"}, 32'(ok), 32'd1);
    endtask

    // Called at a negedge inside a granted cycle: acks it and checks the routed pulse.
    task automatic ack_now(input string nm, input logic [1:0] owner);
        sd_ack = 1'b1;
        #1;
        chk({nm, "_s_ack"}, 32'(s_ack), 32'(owner == 2'b01));
        chk({nm, "_u_ack"}, 32'(u_ack), 32'(owner == 2'b10));
        @(posedge clk);
        #1;
        sd_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        bit saw_ack;

        vecs[0]  = mk(6'b100001, 7'b0000010, 32'h0, 8'd0);
        vecs[1]  = mk(6'b100001, 7'b1010000, SA,    8'd0);
        vecs[2]  = mk(6'b100001, 7'b1010000, SA,    8'd0);
        vecs[3]  = mk(6'b100001, 7'b1010000, SA,    8'd0);
        vecs[4]  = mk(6'b100001, 7'b1010000, SA,    8'd0);
        vecs[5]  = mk(6'b100011, 7'b1011000, SA,    8'd0);
        vecs[6]  = mk(6'b000001, 7'b0000010, 32'h0, 8'd0);
        vecs[7]  = mk(6'b110001, 7'b0000010, 32'h0, 8'd0);
        vecs[8]  = mk(6'b110001, 7'b1010000, SA,    8'd0);
        vecs[9]  = mk(6'b110011, 7'b1011000, SA,    8'd0);
        vecs[10] = mk(6'b010001, 7'b0000010, 32'h0, 8'd0);
        vecs[11] = mk(6'b010001, 7'b1100000, UA,    8'd0);
        vecs[12] = mk(6'b010011, 7'b1100100, UA,    8'd0);
        vecs[13] = mk(6'b000001, 7'b0000010, 32'h0, 8'd0);
        vecs[14] = mk(6'b000011, 7'b0000010, 32'h0, 8'd0);
        vecs[15] = mk(6'b000001, 7'b0000010, 32'h0, 8'd1);
        vecs[16] = mk(6'b001101, 7'b0000000, 32'h0, 8'd1);
        vecs[17] = mk(6'b001101, 7'b0000001, 32'h0, 8'd1);
        vecs[18] = mk(6'b000101, 7'b0000011, 32'h0, 8'd1);
        vecs[19] = mk(6'b000001, 7'b0000010, 32'h0, 8'd1);

        reset_n = 1'b0;
        spi_critical = 1'b0; spi_refresh_inh = 1'b0;
        s_enable = 1'b0; s_we = 1'b0; s_addr = SA; s_wr_data = 16'h1111; s_wr_mask = 2'b11;
        u_enable = 1'b0; u_we = 1'b1; u_addr = UA; u_wr_data = 16'hBEEF; u_wr_mask = 2'b01;
        sd_ack = 1'b0; sd_idle = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sd_enable", 32'(sd_enable), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sd_addr", sd_addr, 32'd0);
        chk("rst_tc", 32'(timeout_count), 32'd0);
        chk("rst_acks", 32'({s_ack, u_ack}), 32'd0);
        chk("rst_u_idle", 32'(u_idle), 32'd0);
        chk("rst_rinh", 32'(sd_refresh_inh), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sd_idle = 1'b1;

        // Single S read, simultaneous S/U, idle-ack timeout event, refresh inhibit.
        for (int i = 0; i < 20; i++) begin
            {s_enable, u_enable, spi_critical, spi_refresh_inh, sd_ack, sd_idle} = vecs[i].in;
            @(negedge clk);
            chk($sformatf("v%0d_sd_enable", i), 32'(sd_enable), 32'(vecs[i].ex[6]));
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].ex[5:4]));
            chk($sformatf("v%0d_s_ack", i), 32'(s_ack), 32'(vecs[i].ex[3]));
            chk($sformatf("v%0d_u_ack", i), 32'(u_ack), 32'(vecs[i].ex[2]));
            chk($sformatf("v%0d_u_idle", i), 32'(u_idle), 32'(vecs[i].ex[1]));
            chk($sformatf("v%0d_rinh", i), 32'(sd_refresh_inh), 32'(vecs[i].ex[0]));
            chk($sformatf("v%0d_tc", i), 32'(timeout_count), 32'(vecs[i].tc));
            if (vecs[i].ex[6])
                chk($sformatf("v%0d_sd_addr", i), sd_addr, vecs[i].addr);
            @(posedge clk);
            #1;
        end
        {s_enable, u_enable, spi_critical, spi_refresh_inh, sd_ack} = 5'b0;
        step();

        // Starvation: 16 S grants, then U is forced in.
        s_enable = 1'b1; u_enable = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            wait_en($sformatf("starve%0d", k));
            chk($sformatf("starve%0d_grant", k), 32'(grant), (k == 17) ? 32'd2 : 32'd1);
            ack_now($sformatf("starve%0d", k), (k == 17) ? 2'b10 : 2'b01);
        end
        s_enable = 1'b0; u_enable = 1'b0;
        step();

        // Critical: U is never granted however long it waits.
        s_enable = 1'b1; u_enable = 1'b1; spi_critical = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wait_en($sformatf("crit%0d", k));
            chk($sformatf("crit%0d_grant", k), 32'(grant), 32'd1);
            ack_now($sformatf("crit%0d", k), 2'b01);
        end
        s_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("crit_hold%0d", k), 32'({sd_enable, grant}), 32'd0);
        end
        @(posedge clk);
        #1;
        u_enable = 1'b0; spi_critical = 1'b0;
        step();

        // Critical rises during a U write: U completes, then S is served.
        u_enable = 1'b1;
        wait_en("uwr");
        chk("uwr_grant", 32'(grant), 32'd2);
        chk("uwr_we", 32'(sd_we), 32'd1);
        chk("uwr_mask", 32'(sd_wr_mask), 32'd1);
        chk("uwr_data", 32'(sd_wr_data), 32'hBEEF);
        chk("uwr_addr", sd_addr, UA);
        @(posedge clk);
        #1;
        spi_critical = 1'b1; s_enable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("uwr_hold", 32'({sd_enable, grant}), 32'b110);
        end
        ack_now("uwr", 2'b10);
        u_enable = 1'b0;
        wait_en("after_u");
        chk("after_u_grant", 32'(grant), 32'd1);
        chk("after_u_we", 32'(sd_we), 32'd0);
        chk("after_u_mask", 32'(sd_wr_mask), 32'd3);
        chk("after_u_no_uack", 32'(u_ack), 32'd0);
        ack_now("after_u", 2'b01);
        s_enable = 1'b0; spi_critical = 1'b0;
        step();

        // Watchdog: no ack for 64 granted cycles.
        s_enable = 1'b1;
        wait_en("wd");
        cnt = 1;
        saw_ack = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            saw_ack = saw_ack | s_ack | u_ack;
            if (!sd_enable) break;
            cnt++;
        end
        chk("wd_cycles", 32'(cnt), 32'd64);
        chk("wd_no_ack", 32'(saw_ack), 32'd0);
        chk("wd_grant", 32'(grant), 32'd0);
        chk("wd_tc", 32'(timeout_count), 32'd2);
        s_enable = 1'b0; sd_idle = 1'b0;
        step();
        sd_ack = 1'b1;
        @(negedge clk);
        chk("flush_late_ack", 32'({s_ack, u_ack}), 32'd0);
        @(posedge clk);
        #1;
        sd_ack = 1'b0; sd_idle = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("flush_exit", 32'({sd_enable, grant}), 32'd0);
        chk("flush_tc", 32'(timeout_count), 32'd2);
        chk("flush_u_idle", 32'(u_idle), 32'd1);

        // Reset in the middle of GRANT_S, then a clean restart.
        s_enable = 1'b1;
        wait_en("rst_mid");
        #2;
        reset_n = 1'b0;
        sd_ack = 1'b1;
        #1;
        chk("rst_mid_enable", 32'(sd_enable), 32'd0);
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_ack", 32'({s_ack, u_ack}), 32'd0);
        chk("rst_mid_tc", 32'(timeout_count), 32'd0);
        sd_ack = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_en("restart");
        chk("restart_grant", 32'(grant), 32'd1);
        chk("restart_addr", sd_addr, SA);
        ack_now("restart", 2'b01);
        s_enable = 1'b0;
        step();
        @(negedge clk);
        chk("restart_idle", 32'({sd_enable, grant}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
